// File: rtl/contador_modulo_if.sv
// contador_modulo_if: control/status bundle for contador_modulo; flag signals exist only with CONTADOR_MODULO_FLAGS_EN.
interface contador_modulo_if #(parameter int WIDTH = 8);
  logic             en;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
`ifdef CONTADOR_MODULO_FLAGS_EN
  logic             ovf_sticky;
  logic             unf_sticky;
  logic             flag_clr;
  modport master (output en, up_down, load, load_val, sat, flag_clr, input count, tc, wrap, ovf_sticky, unf_sticky);
  modport slave  (input en, up_down, load, load_val, sat, flag_clr, output count, tc, wrap, ovf_sticky, unf_sticky);
`else
  modport master (output en, up_down, load, load_val, sat, input count, tc, wrap);
  modport slave  (input en, up_down, load, load_val, sat, output count, tc, wrap);
`endif
endinterface

// File: rtl/contador_modulo.sv
// contador_modulo: up/down modulo counter with load, wrap/saturate policy, tc and wrap pulse.
// Sticky boundary flags are built only when CONTADOR_MODULO_FLAGS_EN is defined.
module contador_modulo #(
  parameter int WIDTH     = 8,
  parameter int MODULUS   = 256,
  parameter int RESET_VAL = 0
) (
  input logic           clk,
  input logic           reset,
  contador_modulo_if.slave bus
);
  if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("contador_modulo: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("contador_modulo: RESET_VAL must be below MODULUS");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULUS);
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_bound, in_range, tc;
  always_comb begin
    at_bound = bus.up_down ? (count_q == MAX) : (count_q == '0);
    in_range = {1'b0, bus.load_val} < MOD;
    tc       = bus.en & ~reset & ~bus.load & at_bound;
    count_d  = bus.load ? (in_range ? bus.load_val : MAX) :
               !bus.en  ? count_q :
               at_bound ? (bus.sat ? count_q : (bus.up_down ? '0 : MAX)) :
               bus.up_down ? count_q + 1'b1 : count_q - 1'b1;
    wrap_d   = ~bus.load & bus.en & at_bound & ~bus.sat;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= WIDTH'(RESET_VAL);
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end
  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = tc;
`ifdef CONTADOR_MODULO_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  // A boundary hit on the same edge as flag_clr keeps the flag set.
  always_comb begin
    ovf_d = (ovf_q & ~bus.flag_clr) | (tc & bus.up_down);
    unf_d = (unf_q & ~bus.flag_clr) | (tc & ~bus.up_down);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign bus.ovf_sticky = ovf_q;
  assign bus.unf_sticky = unf_q;
`endif
endmodule

// File: tb/tb_contador_modulo.sv
// tb_contador_modulo: directed checks of a MODULUS=10 and a MODULUS=256 counter.
module tb_contador_modulo;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  contador_modulo_if #(.WIDTH(8)) b10 ();
  contador_modulo_if #(.WIDTH(8)) b256 ();
  contador_modulo #(.WIDTH(8), .MODULUS(10), .RESET_VAL(0)) d10 (.clk(clk), .reset(reset), .bus(b10));
  contador_modulo #(.WIDTH(8), .MODULUS(256), .RESET_VAL(0)) d256 (.clk(clk), .reset(reset), .bus(b256));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    b10.en = 1'b1; b10.up_down = 1'b1; b10.sat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b10.count !== 8'd0) begin errors++; $display("FAIL reset_count cyc %0d got %0d want 0", i, b10.count); end
      checks++;
      if (b10.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap cyc %0d got %b want 0", i, b10.wrap); end
      checks++;
      if (b10.tc !== 1'b0) begin errors++; $display("FAIL reset_tc cyc %0d got %b want 0", i, b10.tc); end
    end
`ifdef CONTADOR_MODULO_FLAGS_EN
    checks++;
    if (b10.ovf_sticky !== 1'b0 || b10.unf_sticky !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", b10.ovf_sticky, b10.unf_sticky); end
`endif
    reset = 1'b0;
    tick();
    checks++;
    if (b10.count !== 8'd1) begin errors++; $display("FAIL first_up got %0d want 1", b10.count); end
  endtask
  task automatic test_up_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b10.en = 1'b1; b10.up_down = 1'b1; b10.sat = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      checks++;
      if (b10.tc !== ((i - 1) % 10 == 9)) begin errors++; $display("FAIL up_tc step %0d got %b want %b", i, b10.tc, ((i - 1) % 10 == 9)); end
      tick();
      checks++;
      if (b10.count !== 8'(i % 10)) begin errors++; $display("FAIL up_count step %0d got %0d want %0d", i, b10.count, i % 10); end
      checks++;
      if (b10.wrap !== (i == 10)) begin errors++; $display("FAIL up_wrap step %0d got %b want %b", i, b10.wrap, (i == 10)); end
    end
  endtask
  task automatic test_down_sat();
    logic [7:0] exp [5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    b10.en = 1'b0; b10.load = 1'b1; b10.load_val = 8'd2;
`ifdef CONTADOR_MODULO_FLAGS_EN
    b10.flag_clr = 1'b1;
`endif
    tick();
    b10.load = 1'b0;
`ifdef CONTADOR_MODULO_FLAGS_EN
    b10.flag_clr = 1'b0;
    checks++;
    if (b10.ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", b10.ovf_sticky); end
`endif
    checks++;
    if (b10.count !== 8'd2) begin errors++; $display("FAIL load2 got %0d want 2", b10.count); end
    b10.en = 1'b1; b10.up_down = 1'b0; b10.sat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b10.count !== exp[i]) begin errors++; $display("FAIL down_count step %0d got %0d want %0d", i, b10.count, exp[i]); end
      checks++;
      if (b10.wrap !== 1'b0) begin errors++; $display("FAIL down_wrap step %0d got %b want 0", i, b10.wrap); end
      checks++;
      if (b10.tc !== (exp[i] == 8'd0)) begin errors++; $display("FAIL down_tc step %0d got %b want %b", i, b10.tc, (exp[i] == 8'd0)); end
    end
`ifdef CONTADOR_MODULO_FLAGS_EN
    checks++;
    if (b10.unf_sticky !== 1'b1 || b10.ovf_sticky !== 1'b0) begin errors++; $display("FAIL unf_set got %b%b want 01", b10.ovf_sticky, b10.unf_sticky); end
    b10.flag_clr = 1'b1;
    tick();
    checks++;
    if (b10.unf_sticky !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", b10.unf_sticky); end
    b10.en = 1'b0;
    tick();
    checks++;
    if (b10.unf_sticky !== 1'b0) begin errors++; $display("FAIL unf_clr got %b want 0", b10.unf_sticky); end
    b10.flag_clr = 1'b0;
`endif
  endtask
  task automatic test_load();
    logic [7:0] vals [4] = '{8'd7, 8'd200, 8'd9, 8'd10};
    logic [7:0] exp  [4] = '{8'd7, 8'd9, 8'd9, 8'd9};
    b10.en = 1'b1; b10.up_down = 1'b1; b10.sat = 1'b0; b10.load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b10.load_val = vals[i];
      #1;
      checks++;
      if (b10.tc !== 1'b0) begin errors++; $display("FAIL load_tc val %0d got %b want 0", vals[i], b10.tc); end
      tick();
      checks++;
      if (b10.count !== exp[i]) begin errors++; $display("FAIL load_count val %0d got %0d want %0d", vals[i], b10.count, exp[i]); end
      checks++;
      if (b10.wrap !== 1'b0) begin errors++; $display("FAIL load_wrap val %0d got %b want 0", vals[i], b10.wrap); end
    end
    b10.load = 1'b0;
    b10.sat = 1'b1;
    tick();
    checks++;
    if (b10.count !== 8'd9 || b10.wrap !== 1'b0 || b10.tc !== 1'b1) begin errors++; $display("FAIL up_sat got c=%0d w=%b tc=%b want c=9 w=0 tc=1", b10.count, b10.wrap, b10.tc); end
  endtask
  task automatic test_reset_mid_wrap();
    b10.en = 1'b1; b10.up_down = 1'b1; b10.sat = 1'b0; reset = 1'b1;
    tick();
    checks++;
    if (b10.count !== 8'd0 || b10.wrap !== 1'b0) begin errors++; $display("FAIL mid_wrap_reset got c=%0d w=%b want c=0 w=0", b10.count, b10.wrap); end
    reset = 1'b0; b10.en = 1'b0;
    tick();
    checks++;
    if (b10.count !== 8'd0 || b10.wrap !== 1'b0) begin errors++; $display("FAIL mid_wrap_after got c=%0d w=%b want c=0 w=0", b10.count, b10.wrap); end
  endtask
  task automatic test_full_range();
    b256.en = 1'b0; b256.load = 1'b1; b256.load_val = 8'd255; b256.sat = 1'b0; b256.up_down = 1'b1;
    tick();
    b256.load = 1'b0; b256.en = 1'b1;
    #1;
    checks++;
    if (b256.count !== 8'd255 || b256.tc !== 1'b1) begin errors++; $display("FAIL full_load got c=%0d tc=%b want c=255 tc=1", b256.count, b256.tc); end
    tick();
    checks++;
    if (b256.count !== 8'd0 || b256.wrap !== 1'b1) begin errors++; $display("FAIL full_up got c=%0d w=%b want c=0 w=1", b256.count, b256.wrap); end
    b256.up_down = 1'b0;
    tick();
    checks++;
    if (b256.count !== 8'd255 || b256.wrap !== 1'b1) begin errors++; $display("FAIL full_down got c=%0d w=%b want c=255 w=1", b256.count, b256.wrap); end
    b256.en = 1'b0;
    tick();
    checks++;
    if (b256.count !== 8'd255 || b256.wrap !== 1'b0) begin errors++; $display("FAIL full_hold got c=%0d w=%b want c=255 w=0", b256.count, b256.wrap); end
  endtask
  initial begin
    reset = 1'b1;
    b10.en = 1'b0; b10.up_down = 1'b1; b10.load = 1'b0; b10.load_val = '0; b10.sat = 1'b0;
    b256.en = 1'b0; b256.up_down = 1'b1; b256.load = 1'b0; b256.load_val = '0; b256.sat = 1'b0;
`ifdef CONTADOR_MODULO_FLAGS_EN
    b10.flag_clr = 1'b0;
    b256.flag_clr = 1'b0;
`endif
    #2;
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_load();
    test_reset_mid_wrap();
    test_full_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/contador_modulo.md
# contador_modulo

Parametrised synchronous up/down modulo counter: next generation of the 8-bit `contador` block. Adds configurable width and modulus, parallel load, wrap-or-saturate selection, a terminal-count indication and a registered wrap pulse. Used wherever the design needs event or sequence counting with a non-power-of-two range or a runtime-selectable boundary policy.

## Interface

**Parameters** (name, default, meaning)

- `WIDTH`, 8: counter width in bits.
- `MODULUS`, 256: count range is 0..MODULUS-1.
  - Legal range 2 ≤ MODULUS ≤ 2^WIDTH.
  - Elaboration error otherwise.
- `RESET_VAL`, 0: value loaded on reset. Must be < MODULUS (elaboration error otherwise).

**Ports** (name, direction, width, meaning)

- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `en`, in, 1: count enable.
- `up_down`, in, 1: 1 = count up, 0 = count down.
- `load`, in, 1: parallel load strobe.
- `load_val`, in, WIDTH: value to load.
- `sat`, in, 1: boundary policy. 1 = saturate, 0 = wrap.
- `count`, out, WIDTH: current count (registered).
- `tc`, out, 1: terminal count (combinational).
- `wrap`, out, 1: registered single-cycle wrap pulse.
- `ovf_sticky`, out, 1: sticky up-boundary flag. Present only with `CONTADOR_MODULO_FLAGS_EN`.
- `unf_sticky`, out, 1: sticky down-boundary flag. Present only with `CONTADOR_MODULO_FLAGS_EN`.
- `flag_clr`, in, 1: clears both sticky flags. Present only with `CONTADOR_MODULO_FLAGS_EN`.

## Operation

- Priority at each rising edge: `reset` > `load` > `en` > hold.
- **Reset:**
  - `count` = RESET_VAL.
  - `wrap` = 0.
  - Sticky flags = 0.
  - Reset mid-count aborts any pending wrap pulse.
- **Load:**
  - `count` = `load_val` when `load_val` < MODULUS.
  - Otherwise `count` = MODULUS-1 (clamped).
  - `en` is ignored in that cycle.
  - `wrap` = 0.
- **Enabled count, up (`up_down`=1):**
  - `count` < MODULUS-1: `count` + 1.
  - `count` = MODULUS-1 and `sat`=0: `count` becomes 0, `wrap` asserts.
  - `count` = MODULUS-1 and `sat`=1: `count` holds, no `wrap`.
- **Enabled count, down (`up_down`=0):**
  - `count` > 0: `count` − 1.
  - `count` = 0 and `sat`=0: `count` becomes MODULUS-1, `wrap` asserts.
  - `count` = 0 and `sat`=1: `count` holds, no `wrap`.
- **`tc`:**
  - `tc` = `en` & (`up_down` ? `count`==MODULUS-1 : `count`==0).
  - Asserted regardless of `sat`.
  - Forced to 0 while `reset` or `load` is high.
- `up_down` and `sat` may change on any cycle; the value sampled at the edge governs that step.
- Arithmetic is unsigned, WIDTH bits. When MODULUS = 2^WIDTH, wrap is the natural overflow.

## Timing

- `count` latency: 1 cycle from the sampling edge of `en`/`load`/`reset`.
- `wrap` is high for exactly the one cycle following the edge on which the wrap took place, coincident with the new `count` value.
- `tc` is combinational from `count`, `en` and `up_down`; it has no registered delay.
- Sticky flags (with the macro) assert on the edge where an enabled step reaches the boundary (`tc` high), whether the step wrapped or saturated.
- **Reset values:** `count`=RESET_VAL, `wrap`=0, `ovf_sticky`=0, `unf_sticky`=0. `tc` follows from these values.

## Configuration

- Macro: `CONTADOR_MODULO_FLAGS_EN`.
- **Defined:**
  - Adds `ovf_sticky`, `unf_sticky` and `flag_clr`.
  - `ovf_sticky` sets on an enabled up step with `tc`=1.
  - `unf_sticky` sets on an enabled down step with `tc`=1.
  - Both hold until `flag_clr`=1 or `reset`.
  - If a set and `flag_clr` occur on the same edge, set wins.
- **Undefined:** ports and flag logic are absent. All other behaviour is identical.

## Test plan

(WIDTH=8, MODULUS=10, RESET_VAL=0 unless stated.)

- **Reset:** hold `reset`=1 for 5 cycles with `en`=1 → `count`=0, `wrap`=0 throughout. First enabled up edge after release → `count`=1.
- **Up wrap:** `en`=1, `up_down`=1, `sat`=0 for 12 cycles from 0 → counts 1..9, then 0 with `wrap`=1 for one cycle, then 1, 2. `tc`=1 only while `count`=9.
- **Down saturate:** load 2, then `en`=1, `up_down`=0, `sat`=1 for 5 cycles → counts 1, 0, 0, 0, 0. `wrap` never asserts; `tc`=1 while `count`=0. With the macro, `unf_sticky`=1 until `flag_clr`.
- **Load priority and clamp:**
  - `load`=1, `load_val`=7, `en`=1, `up_down`=1 → `count`=7, not 8.
  - `load_val`=200 → `count`=9.
- **Reset mid-wrap:** `count`=9, up, `en`=1, `reset`=1 on the same edge → `count`=0, `wrap`=0.
- **Full-range wrap:** MODULUS=256, `count`=255, up, `sat`=0 → `count`=0, `wrap`=1. Then down from 0 → `count`=255, `wrap`=1.
